// File: rtl/crc_req_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crc_req_scheduler
// Purpose  : Two-port round-robin arbiter and sequencer for a serial CRC-8 engine.
// Revision : 1.0
// ============================================================================
module crc_req_scheduler #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              crc_rst,
    output logic              crc_active,
    output logic [DATA_W-1:0] crc_data,
    input  logic              crc_out,
    input  logic              crc_valid
);

    localparam int CNT_W = $clog2((TIMEOUT > DATA_W) ? TIMEOUT : DATA_W);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_nbit;
    logic [DATA_W-1:0] r_shreg;
    logic              r_last;
    logic              r_abort;
    logic              w_win;
    logic              w_last_sample;
    logic              w_timeout_hit;
    logic [DATA_W-1:0] w_collect_next;

    always_comb begin
        w_win          = 1'b0;
        w_collect_next = r_shreg;
        w_next_state   = r_state;
        // Contention goes to whoever was not served last; a lone request always wins.
        if (req == 2'b11) begin
            w_win = ~r_last;
        end else begin
            w_win = ~req[0];
        end
        if (crc_valid) begin
            w_collect_next[r_nbit] = crc_out;
        end
        w_last_sample = crc_valid && (r_nbit == BIT_W'(DATA_W - 1));
        w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
        case (r_state)
            S_IDLE:    if (|req) w_next_state = S_ARM;
            S_ARM:     w_next_state = S_SHIFT;
            S_SHIFT:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next_state = S_COLLECT;
            S_COLLECT: if (w_last_sample || w_timeout_hit) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_nbit   <= '0;
            r_shreg  <= '0;
            r_last   <= 1'b1;
            r_abort  <= 1'b0;
            gnt      <= 2'b00;
            crc_rst  <= 1'b0;
            crc_data <= '0;
            result   <= '0;
        end else begin
            r_state <= w_next_state;
            crc_rst <= (w_next_state != S_ARM);
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        gnt      <= w_win ? 2'b10 : 2'b01;
                        r_last   <= w_win;
                        crc_data <= w_win ? data1 : data0;
                    end
                end
                S_ARM: begin
                    r_cnt   <= '0;
                    r_nbit  <= '0;
                    r_shreg <= '0;
                    r_abort <= 1'b0;
                end
                S_SHIFT: begin
                    r_cnt <= (w_next_state == S_COLLECT) ? '0 : r_cnt + 1'b1;
                end
                S_COLLECT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (crc_valid) begin
                        r_shreg <= w_collect_next;
                        r_nbit  <= r_nbit + 1'b1;
                    end
                    // A final sample landing on the timeout cycle still counts as success.
                    if (w_next_state == S_DONE) begin
                        r_abort <= ~w_last_sample;
                        result  <= w_last_sample ? w_collect_next : '0;
                    end
                end
                S_DONE: begin
                    gnt <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_DONE) && r_abort;
    assign crc_active = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_crc_req_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// Directed table-driven bench for crc_req_scheduler with a bench-side CRC-8 engine model.
module tb_crc_req_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;
    logic       crc_rst;
    logic       crc_active;
    logic [7:0] crc_data;
    logic       crc_out = 1'b0;
    logic       crc_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_result = 8'h00;

    always #5 clk = ~clk;

    crc_req_scheduler #(.DATA_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .busy(busy), .done(done), .result(result), .err(err),
        .crc_rst(crc_rst), .crc_active(crc_active), .crc_data(crc_data),
        .crc_out(crc_out), .crc_valid(crc_valid)
    );

    // mode: 0 = valid cycles 10..17, 1 = valid on every other cycle from 10, 2 = never valid
    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         mode;
        logic       use_pat;
        logic [7:0] pat;
        logic       spur;
        logic       drop;
        logic [1:0] exp_gnt;
        logic [7:0] exp_byte;
        logic       exp_err;
        int         done_c;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                                input int m, input logic up, input logic [7:0] p,
                                input logic sp, input logic dr, input logic [1:0] g,
                                input logic [7:0] eb, input logic ee, input int dc);
        vec_t v;
        v.req = r; v.d0 = a; v.d1 = b; v.mode = m; v.use_pat = up; v.pat = p;
        v.spur = sp; v.drop = dr; v.exp_gnt = g; v.exp_byte = eb; v.exp_err = ee; v.done_c = dc;
        return v;
    endfunction

    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_crc_active", 32'(crc_active), 32'd0);
        chk("rst_crc_data", 32'(crc_data), 32'd0);
        chk("rst_crc_rst", 32'(crc_rst), 32'd0);
    endtask

    // Called in an IDLE cycle, which becomes cycle 0 of the job; returns in the IDLE cycle after DONE.
    task automatic run_job(input vec_t v);
        logic [7:0] eng;
        logic [7:0] exp_res;
        logic [2:0] idx;
        eng = 8'h00;
        req = v.req; data0 = v.d0; data1 = v.d1;
        crc_valid = 1'b0; crc_out = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        exp_res = v.exp_err ? 8'h00 : (v.use_pat ? v.pat : crc8(v.exp_byte));
        for (int c = 1; c <= v.done_c + 1; c++) begin
            step();
            crc_valid = 1'b0; crc_out = 1'b0;
            if (v.drop && c == 4) req = 2'b00;
            if (v.spur && c >= 2 && c <= 9) begin
                crc_valid = 1'b1; crc_out = 1'b1;
            end
            if (c == 2) eng = v.use_pat ? v.pat : crc8(crc_data);
            if (v.mode == 0 && c >= 10 && c <= 17) begin
                idx = 3'(c - 10);
                crc_valid = 1'b1; crc_out = eng[idx];
            end
            if (v.mode == 1 && c >= 10 && c <= 24 && (c % 2) == 0) begin
                idx = 3'((c - 10) / 2);
                crc_valid = 1'b1; crc_out = eng[idx];
            end
            chk("gnt", 32'(gnt), 32'((c <= v.done_c) ? v.exp_gnt : 2'b00));
            chk("busy", 32'(busy), 32'(c <= v.done_c));
            chk("crc_rst", 32'(crc_rst), 32'(c != 1));
            chk("crc_active", 32'(crc_active), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) chk("crc_data", 32'(crc_data), 32'(v.exp_byte));
            chk("done", 32'(done), 32'(c == v.done_c));
            chk("err", 32'(err), 32'(c == v.done_c && v.exp_err));
            if (c < v.done_c) chk("result_hold", 32'(result), 32'(prev_result));
            else              chk("result", 32'(result), 32'(exp_res));
        end
        prev_result = exp_res;
        crc_valid = 1'b0; crc_out = 1'b0;
    endtask

    initial begin
        //           req    d0     d1     mode up  pat    sp   dr   gnt    byte   err  done
        vecs[0] = mk(2'b11, 8'hA1, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA1, 1'b0, 18);
        vecs[1] = mk(2'b11, 8'hA1, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'h3C, 1'b0, 18);
        vecs[2] = mk(2'b11, 8'hA1, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'hA1, 1'b0, 18);
        vecs[3] = mk(2'b01, 8'h93, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h93, 1'b0, 18);
        vecs[4] = mk(2'b10, 8'h93, 8'h5A, 1, 1'b1, 8'h4D, 1'b0, 1'b0, 2'b10, 8'h5A, 1'b0, 25);
        vecs[5] = mk(2'b01, 8'hE4, 8'h5A, 2, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'hE4, 1'b1, 26);
        vecs[6] = mk(2'b10, 8'hE4, 8'hC7, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'hC7, 1'b0, 18);
        vecs[7] = mk(2'b01, 8'h66, 8'hC7, 0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h66, 1'b0, 18);

        rst = 1'b0;
        repeat (3) step();
        chk_reset_values();
        rst = 1'b1;
        step();
        chk("release_crc_rst", 32'(crc_rst), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i]);
        end

        // Reset in the middle of SHIFT with requester 1 in flight.
        req = 2'b10; data1 = 8'h77;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("pre_rst_done", 32'(done), 32'd0);
        end
        chk("pre_rst_active", 32'(crc_active), 32'd1);
        rst = 1'b0;
        step();
        chk_reset_values();
        step();
        chk("hold_rst_crc_rst", 32'(crc_rst), 32'd0);
        chk("hold_rst_done", 32'(done), 32'd0);
        rst = 1'b1; req = 2'b00;
        step();
        chk("post_rst_crc_rst", 32'(crc_rst), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        prev_result = 8'h00;
        run_job(mk(2'b11, 8'hB2, 8'h77, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'hB2, 1'b0, 18));

        req = 2'b00;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_req_scheduler.md
# crc_req_scheduler

Sequencer and two-port arbiter for the shared 8-bit serial CRC engine (`CRC`). It grants one requester at a time and latches that requester's byte. It then drives the engine through a full cycle: reset pulse, 8 `active` cycles, and collection of the 8 serially emitted `crc_out` bits into a parallel result. It sits between byte producers and the single `CRC` instance, so no producer touches engine ports directly.

## Interface
- `DATA_W`, 8, byte width fed to the engine; it is also the number of `active` cycles and the number of collected CRC bits.
- `TIMEOUT`, 16, maximum number of cycles spent in COLLECT before aborting with `err`.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in 2: per-requester request; `req[i]` is held high until `done` with `gnt[i]` set.
- `data0` in DATA_W: requester 0 byte.
- `data1` in DATA_W: requester 1 byte.
- `gnt` out 2: one-hot grant, held from ARM through DONE inclusive.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `result` out DATA_W: collected CRC; it is stable from DONE until the next DONE.
- `err` out 1: high in the DONE cycle only, and only when a timeout occurred.
- `crc_rst` out 1: active-low reset to the engine.
- `crc_active` out 1: engine `active` input.
- `crc_data` out DATA_W: engine `Data` input.
- `crc_out` in 1: engine serial CRC output.
- `crc_valid` in 1: engine `valid` output.

## Operation
- States: IDLE → ARM → SHIFT → COLLECT → DONE → IDLE.
- **IDLE**
  - Outputs: `crc_active`=0, `gnt`=0, `crc_rst`=1.
  - If any `req` bit is high, pick the winner with round-robin, latch the winner's data, and go to ARM.
- **Round-robin**
  - The `last` pointer resets to 1, so requester 0 wins first after reset.
  - If both request, the winner is the one not equal to `last`.
  - A lone request always wins.
  - `last` updates on entry to ARM.
- **ARM** (exactly 1 cycle)
  - `crc_rst`=0, `gnt` set, bit counter cleared, collect shift register cleared.
- **SHIFT** (exactly DATA_W cycles)
  - `crc_active`=1, `crc_data`=latched byte.
  - `crc_valid` is ignored in this state.
  - Counter runs 0..DATA_W-1; at DATA_W-1 go to COLLECT.
- **COLLECT**
  - `crc_active`=0; `crc_data` holds the latched byte.
  - On each cycle with `crc_valid`=1, store `crc_out` into `result` bit position `n` and increment `n`. Bit order is LSB first.
  - Gaps in `crc_valid` are allowed.
  - After DATA_W samples, go to DONE.
  - If the cycle counter reaches TIMEOUT with fewer than DATA_W samples, set the abort flag and go to DONE.
- **DONE** (1 cycle)
  - `done`=1.
  - `result` is loaded with the collected value, or with 0 on abort.
  - `err` equals the abort flag.
  - Next state is IDLE.
- Dropping `req` while granted has no effect: the operation completes and `done` still pulses.
- `crc_valid` pulses beyond DATA_W samples, and any pulses outside COLLECT, are ignored.

## Timing
- **Reset values:** while `rst`=0 at a clock edge, the next state is:
  - IDLE
  - `gnt`=0, `busy`=0, `done`=0, `err`=0, `result`=0
  - `crc_active`=0, `crc_data`=0
  - `crc_rst`=0 for the whole time reset is held; it returns to 1 on the first edge after release
  - `last`=1
- **Reset mid-operation:** takes effect at the next edge, regardless of state. No `done` is produced for the aborted job.
- **Latency** (cycle 0 = IDLE edge sampling `req`):
  - ARM in cycle 1; SHIFT in cycles 2..9.
  - COLLECT starts in cycle 10.
  - DONE is one cycle after the cycle holding the 8th valid sample.
  - Minimum total is 19 cycles (cycles 0..18) when `crc_valid` is high in cycles 10..17.
- **Back-to-back jobs:** a request held through DONE is re-sampled in the following IDLE cycle. There is one idle cycle between jobs.
- **Requester data:** sampled only at the IDLE→ARM edge; later changes do not affect the job in flight.

## Test plan
- **Single request:** `req`=01, `data0`=8'h93, engine model returns valid in cycles 10..17.
  - `gnt`=01 in cycles 1..18.
  - `crc_rst`=0 only in cycle 1.
  - `crc_active`=1 with `crc_data`=8'h93 in cycles 2..9.
  - `done` in cycle 18; `result` equals the model's CRC of 8'h93.
- **Simultaneous requests:** `req`=11 right after reset, held.
  - Grant sequence is 01, 10, 01 across three jobs.
  - Each `done` carries the matching byte's CRC.
- **Serial assembly with gaps:** model emits `crc_out` 1,0,1,1,0,0,1,0 with `crc_valid` low on alternate cycles.
  - `result`=8'h4D, `err`=0.
- **Timeout:** `crc_valid` tied 0.
  - DONE occurs TIMEOUT cycles after COLLECT entry, with `done`=1, `err`=1, `result`=8'h00.
  - The next job then runs normally.
- **Reset mid-SHIFT:** `rst`=0 in cycle 5 with `req`=10 pending.
  - Next edge gives all reset values; no `done` pulses.
  - After release, `req`=11 gives `gnt`=01 first.
- **Spurious valid and dropped req:**
  - `crc_valid`=1 with `crc_out`=1 during SHIFT does not alter `result`.
  - Dropping `req` in cycle 4 still yields `done` in cycle 18.
